three_behave: RTL and testbench

Registered magnitude comparator for two WIDTH-bit operands. On each accepted sample it produces one-hot greater/less/equal flags and the absolute difference, with a selectable signed or unsigned interpretation. Saturating event counters accumulate how often each outcome occurs. It sits in the datapath wherever a clean, clocked compare result with one cycle of latency is needed.

---
 rtl/three_behave.sv | 112 +++++++++++
 tb/tb_three_behave.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/three_behave.sv
// three_behave: registered magnitude comparator with outcome counters.
//
// Compares two WIDTH-bit operands as either unsigned or two's-complement
// values. Each accepted sample (in_valid=1) registers one-hot G/L/E flags and
// the absolute difference D, and bumps a saturating counter for its outcome.
// The latency is one cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (clears flags, D, counters)
//   in_valid     accept A/B/signed_mode this cycle
//   A, B         WIDTH-bit operands
//   signed_mode  1 = two's-complement compare, 0 = unsigned
//   cnt_clr      synchronous clear of all counters (wins over a same-cycle count)
//   out_valid    one-cycle pulse when G/L/E/D carry a new result
//   G, L, E      A > B, A < B, A == B
//   D            |A - B| as an unsigned WIDTH-bit magnitude
//   cnt_g/l/e    saturating outcome counters
module three_behave #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             G,
  output logic             L,
  output logic             E,
  output logic [WIDTH-1:0] D,
  output logic [CNT_W-1:0] cnt_g,
  output logic [CNT_W-1:0] cnt_l,
  output logic [CNT_W-1:0] cnt_e
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] b_ext;
  logic                  gt;
  logic                  lt;
  logic        [WIDTH:0] diff;

  // Stage p0: combinational compare. Both operands are widened by one bit
  // (sign- or zero-extended) so one signed comparator serves both modes and
  // max - min always fits without overflow.
  always_comb begin
    a_ext = signed_mode ? {A[WIDTH-1], A} : {1'b0, A};
    b_ext = signed_mode ? {B[WIDTH-1], B} : {1'b0, B};
    gt    = a_ext > b_ext;
    lt    = a_ext < b_ext;
    diff  = gt ? (a_ext - b_ext) : (b_ext - a_ext);
  end

  logic             vld_p1;
  logic             g_p1;
  logic             l_p1;
  logic             e_p1;
  logic [WIDTH-1:0] d_p1;
  logic [CNT_W-1:0] cnt_g_p1;
  logic [CNT_W-1:0] cnt_l_p1;
  logic [CNT_W-1:0] cnt_e_p1;

  // Stage p1: registered results. Results must read zero after reset, so
  // the data registers are cleared along with the control path.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      g_p1     <= 1'b0;
      l_p1     <= 1'b0;
      e_p1     <= 1'b0;
      d_p1     <= '0;
      cnt_g_p1 <= '0;
      cnt_l_p1 <= '0;
      cnt_e_p1 <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        g_p1 <= gt;
        l_p1 <= lt;
        e_p1 <= ~(gt | lt);
        d_p1 <= diff[WIDTH-1:0];
      end
      if (cnt_clr) begin
        cnt_g_p1 <= '0;
        cnt_l_p1 <= '0;
        cnt_e_p1 <= '0;
      end else if (in_valid) begin
        if (gt)      cnt_g_p1 <= sat_inc(cnt_g_p1);
        else if (lt) cnt_l_p1 <= sat_inc(cnt_l_p1);
        else         cnt_e_p1 <= sat_inc(cnt_e_p1);
      end
    end
  end

  assign out_valid = vld_p1;
  assign G         = g_p1;
  assign L         = l_p1;
  assign E         = e_p1;
  assign D         = d_p1;
  assign cnt_g     = cnt_g_p1;
  assign cnt_l     = cnt_l_p1;
  assign cnt_e     = cnt_e_p1;

endmodule

// File: tb/tb_three_behave.sv
// Scoreboard bench for three_behave (WIDTH=4, CNT_W=2 so saturation is
// reachable quickly). The driver pushes hand-computed expectations into a
// queue as each sample is issued; a monitor pops and compares whenever
// out_valid is seen, and checks that outputs hold while out_valid is low.
module tb_three_behave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       signed_mode = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       out_valid;
  logic       G;
  logic       L;
  logic       E;
  logic [3:0] D;
  logic [1:0] cnt_g;
  logic [1:0] cnt_l;
  logic [1:0] cnt_e;

  three_behave #(.WIDTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
    .signed_mode(signed_mode), .cnt_clr(cnt_clr), .out_valid(out_valid),
    .G(G), .L(L), .E(E), .D(D), .cnt_g(cnt_g), .cnt_l(cnt_l), .cnt_e(cnt_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       g;
    logic       l;
    logic       e;
    logic [3:0] d;
    logic [1:0] cg;
    logic [1:0] cl;
    logic [1:0] ce;
  } exp_t;

  exp_t q[$];
  exp_t last;
  bit   have_last = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic chk_exp(input string tag, input exp_t x);
    chk({tag, ".G"}, G, x.g);
    chk({tag, ".L"}, L, x.l);
    chk({tag, ".E"}, E, x.e);
    chk({tag, ".D"}, D, x.d);
    chk({tag, ".cnt_g"}, cnt_g, x.cg);
    chk({tag, ".cnt_l"}, cnt_l, x.cl);
    chk({tag, ".cnt_e"}, cnt_e, x.ce);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          last = q.pop_front();
          chk_exp(last.name, last);
          have_last = 1'b1;
        end
      end else if (have_last) begin
        chk_exp({"hold_after_", last.name}, last);
      end
    end
  end

  task automatic issue(input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic sm, input logic clr,
                       input logic g, input logic l, input logic e, input logic [3:0] d,
                       input logic [1:0] cg, input logic [1:0] cl, input logic [1:0] ce);
    exp_t x;
    A = a; B = b; signed_mode = sm; cnt_clr = clr; in_valid = 1'b1;
    x.name = name; x.g = g; x.l = l; x.e = e; x.d = d;
    x.cg = cg; x.cl = cl; x.ce = ce;
    q.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".G"}, G, 0);
    chk({tag, ".L"}, L, 0);
    chk({tag, ".E"}, E, 0);
    chk({tag, ".D"}, D, 0);
    chk({tag, ".cnt_g"}, cnt_g, 0);
    chk({tag, ".cnt_l"}, cnt_l, 0);
    chk({tag, ".cnt_e"}, cnt_e, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    //            name       A     B     sm clr  G L E  D      cg cl ce
    issue("u4v5",   4'h4, 4'h5, 0, 0,   0, 1, 0, 4'd1,  0, 1, 0);
    issue("u6v8",   4'h6, 4'h8, 0, 0,   0, 1, 0, 4'd2,  0, 2, 0);
    repeat (3) @(negedge clk);
    issue("u9v3",   4'h9, 4'h3, 0, 0,   1, 0, 0, 4'd6,  1, 2, 0);
    issue("u5v5",   4'h5, 4'h5, 0, 0,   0, 0, 1, 4'd0,  1, 2, 1);
    issue("uFv1",   4'hF, 4'h1, 0, 0,   1, 0, 0, 4'd14, 2, 2, 1);
    issue("sFv1",   4'hF, 4'h1, 1, 0,   0, 1, 0, 4'd2,  2, 3, 1);
    issue("s7v8",   4'h7, 4'h8, 1, 0,   1, 0, 0, 4'd15, 3, 3, 1);
    issue("s8v7",   4'h8, 4'h7, 1, 0,   0, 1, 0, 4'd15, 3, 3, 1);
    issue("u8v7",   4'h8, 4'h7, 0, 0,   1, 0, 0, 4'd1,  3, 3, 1);
    // Clear together with a sample: counters zero, flags still update.
    issue("clr_e",  4'h2, 4'h2, 0, 1,   0, 0, 1, 4'd0,  0, 0, 0);
    issue("e1",     4'h3, 4'h3, 0, 0,   0, 0, 1, 4'd0,  0, 0, 1);
    issue("e2",     4'hA, 4'hA, 1, 0,   0, 0, 1, 4'd0,  0, 0, 2);
    issue("e3",     4'h0, 4'h0, 0, 0,   0, 0, 1, 4'd0,  0, 0, 3);
    issue("e4",     4'hF, 4'hF, 1, 0,   0, 0, 1, 4'd0,  0, 0, 3);
    issue("e5",     4'h8, 4'h8, 0, 0,   0, 0, 1, 4'd0,  0, 0, 3);
    issue("u0vF",   4'h0, 4'hF, 0, 0,   0, 1, 0, 4'd15, 0, 1, 3);
    repeat (2) @(negedge clk);

    // Reset coinciding with a valid sample: the sample must be discarded.
    have_last = 1'b0;
    rst = 1'b1; in_valid = 1'b1; A = 4'h9; B = 4'h3; signed_mode = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk_zero("rst_with_valid");
    @(negedge clk);
    chk_zero("after_rst_idle");
    issue("post_rst", 4'h3, 4'h9, 0, 0,  0, 1, 0, 4'd6,  0, 1, 0);

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
